// File: rtl/cnt_seq_ctrl.sv
// Start/stop counter sequencer: counts from 0 up to a latched limit, with
// pause (hold), abort (clear), auto-restart (reload) and a one-cycle done pulse.
module cnt_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hold,
   input  logic             clear,
   input  logic             reload,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic [1:0]       state,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10,
      DONE = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lim_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lim_q   <= lim_d;
         done_q  <= done_d;
      end
   end

   // clear overrides everything; hold only matters once a sequence is running
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      done_d  = 1'b0;
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  lim_d   = limit;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  cnt_d = (state_q == DONE) ? lim_q : '0;
               end
            end
            RUN: begin
               if (hold) begin
                  state_d = HOLD;
               end else if (cnt_q == lim_q) begin
                  done_d = 1'b1;
                  if (reload) begin
                     cnt_d = '0;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (!hold) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign cnt   = cnt_q;
   assign state = state_q;
   assign done  = done_q;
   assign busy  = (state_q == RUN) || (state_q == HOLD);
   assign tc    = (state_q == RUN) && (cnt_q == lim_q);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: a cycle model pushes expected results
// into a queue as each stimulus is driven; they are popped after the clock edge.
module tb_cnt_seq_ctrl;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, hold, clear, reload;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] cnt;
   logic [1:0]       state;
   logic             busy, tc, done;

   typedef struct {
      logic [1:0]       st;
      logic [WIDTH-1:0] c;
      logic             d;
   } expT;

   expT expQ[$];

   int checkCount = 0;
   int errorCount = 0;

   int               modelSt;
   logic [WIDTH-1:0] modelCnt, modelLim;
   logic             modelDone;

   cnt_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .hold   (hold),
      .clear  (clear),
      .reload (reload),
      .limit  (limit),
      .cnt    (cnt),
      .state  (state),
      .busy   (busy),
      .tc     (tc),
      .done   (done)
   );

   // free-running 10ns clock
   always #5 clk = ~clk;

   // one comparison: count it, report it if it disagrees
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // reference behaviour for one rising edge, computed from the current inputs
   task automatic modelStep();
      int               nSt;
      logic [WIDTH-1:0] nCnt, nLim;
      logic             nDone;
      nSt   = modelSt;
      nCnt  = modelCnt;
      nLim  = modelLim;
      nDone = 1'b0;
      if (clear) begin
         nSt  = 0;
         nCnt = '0;
      end else if (modelSt == 1) begin
         if (hold) nSt = 2;
         else if (modelCnt != modelLim) nCnt = modelCnt + 1'b1;
         else begin
            nDone = 1'b1;
            if (reload) nCnt = '0;
            else nSt = 3;
         end
      end else if (modelSt == 2) begin
         if (!hold) nSt = 1;
      end else if (start) begin
         nLim = limit;
         nCnt = '0;
         nSt  = 1;
      end else begin
         nCnt = (modelSt == 3) ? modelLim : '0;
      end
      modelSt   = nSt;
      modelCnt  = nCnt;
      modelLim  = nLim;
      modelDone = nDone;
   endtask

   task automatic modelReset();
      modelSt   = 0;
      modelCnt  = '0;
      modelLim  = '0;
      modelDone = 1'b0;
      expQ.delete();
   endtask

   // drive one cycle of inputs, predict, then compare after the edge
   task automatic applyStimulus(input logic s, input logic h, input logic c,
                                input logic r, input logic [WIDTH-1:0] lim);
      expT e;
      @(negedge clk);
      start  = s;
      hold   = h;
      clear  = c;
      reload = r;
      limit  = lim;
      #1;
      checkOutput("busy", 32'(busy), 32'(modelSt == 1 || modelSt == 2));
      checkOutput("tc", 32'(tc), 32'(modelSt == 1 && modelCnt == modelLim));
      modelStep();
      e.st = 2'(modelSt);
      e.c  = modelCnt;
      e.d  = modelDone;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         checkOutput("queue_empty", 32'd1, 32'd0);
      end else begin
         e = expQ.pop_front();
         checkOutput("state", 32'(state), 32'(e.st));
         checkOutput("cnt", 32'(cnt), 32'(e.c));
         checkOutput("done", 32'(done), 32'(e.d));
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, limit);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_state"}, 32'(state), 32'd0);
      checkOutput({tag, "_cnt"}, 32'(cnt), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_tc"}, 32'(tc), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      hold   = 1'b0;
      clear  = 1'b0;
      reload = 1'b0;
      limit  = '0;
      modelReset();
      #1;
      checkResetState("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] basic count to 3");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
      idleCycles(5);
      checkOutput("basic_hold_cnt", 32'(cnt), 32'd3);
      checkOutput("basic_in_done", 32'(state), 32'd3);

      $display("[TB] periodic reload, limit 2");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
      checkOutput("periodic_run", 32'(state), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

      $display("[TB] hold mid-count and at terminal");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
      idleCycles(2);
      checkOutput("hold_cnt_before", 32'(cnt), 32'd2);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
      checkOutput("hold_state", 32'(state), 32'd2);
      idleCycles(4);
      checkOutput("hold_at_five", 32'(cnt), 32'd5);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
      idleCycles(3);

      $display("[TB] clear then limit 0");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
      idleCycles(4);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
      checkOutput("clear_cnt", 32'(cnt), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      idleCycles(3);

      $display("[TB] async reset mid-run");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
      idleCycles(6);
      @(negedge clk);
      #2;
      rst   = 1'b1;
      start = 1'b1;
      limit = 4'd3;
      #1;
      checkResetState("async");
      @(posedge clk);
      #1;
      checkResetState("async_start");
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      modelReset();
      idleCycles(2);

      $display("[TB] start ignored while running");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

      $display("[TB] full-range limit");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
      idleCycles(18);

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
